// File: rtl/mem_pkg.sv
// Shared types and widths for the memory stage.
// Pure declarations: no logic, no latency.
// Used by mem_access_unit and its testbench.
package mem_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts BUSY cycles spent waiting on the data memory.
// One cycle per count. tc is combinational and is high when this enabled cycle brings the count to MAX_WAIT.
// clear has priority over enable. No backpressure.
module mem_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count;

    // Wait-cycle counter, held at zero outside an outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // The count before this cycle's increment is MAX_WAIT-1, so this enabled
    // cycle is the MAX_WAIT-th BUSY cycle without an answer.
    assign tc = enable && (count == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues a single-cycle req to a variable-latency data memory and freezes upstream until it answers.
// Latency: a memory answer k cycles after req gives k+1 stall cycles. A non-memory op passes through combinationally.
// Timeout after MAX_WAIT BUSY cycles. Define MEM_ALIGN_CHECK_EN to reject odd addresses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_MemWrite,
    input  logic [WORD_W-1:0]     MEM_addr,
    input  logic [WORD_W-1:0]     MEM_store_data,
    input  logic                  MEM_Reg_Write,
    input  logic [REG_ADDR_W-1:0] MEM_dst_reg,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_valid,
    output logic                  mem_stall,
    output logic                  out_Reg_Write,
    output logic [REG_ADDR_W-1:0] out_dst_reg,
    output logic [WORD_W-1:0]     out_Write_data,
    output logic [WORD_W-1:0]     out_Read_data,
    output logic                  mem_err
);

    mem_state_t        state;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              mem_op;
    logic              misaligned;
    logic              issue;
    logic              wait_tc;

    assign mem_op = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & MEM_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // The request goes out in the same cycle the op is seen in IDLE. It is gated
    // by rst so that nothing leaves the block while reset is held.
    assign issue = (state == IDLE) & mem_op & ~misaligned & ~rst;

    mem_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != BUSY),
        .enable (state == BUSY),
        .tc     (wait_tc)
    );

    // Access sequencing: capture the request, wait for valid or timeout, then present once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        mem_err <= 1'b1;
                    end
                    if (issue) begin
                        we_q    <= MEM_MemWrite;
                        addr_q  <= MEM_addr;
                        wdata_q <= MEM_store_data;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_valid) begin
                        if (!we_q) begin
                            rdata_q <= dmem_rdata;
                        end
                        state <= DONE;
                    end else if (wait_tc) begin
                        mem_err <= 1'b1;
                        rdata_q <= '0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // The frozen instruction is presented this cycle. The next one is taken in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port: live fields on the issue cycle, captured fields afterwards
    always_comb begin
        dmem_req   = issue;
        dmem_we    = (state == IDLE) ? MEM_MemWrite   : we_q;
        dmem_addr  = (state == IDLE) ? MEM_addr       : addr_q;
        dmem_wdata = (state == IDLE) ? MEM_store_data : wdata_q;
    end

    // MEM/WB fields. A bubble is inserted on every stalled or rejected cycle.
    always_comb begin
        mem_stall      = issue | (state == BUSY);
        out_Reg_Write  = ((state == IDLE) & ~mem_op & ~rst) |
                         ((state == DONE) & MEM_Reg_Write);
        out_dst_reg    = MEM_dst_reg;
        out_Write_data = MEM_addr;
        out_Read_data  = (state == DONE) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (default build, MAX_WAIT = 15).
// Inputs change 1 time unit after posedge. Outputs are sampled on negedge.
// The memory side is driven by hand per scenario.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [15:0] MEM_addr;
    logic [15:0] MEM_store_data;
    logic        MEM_Reg_Write;
    logic [3:0]  MEM_dst_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_valid;
    logic        mem_stall;
    logic        out_Reg_Write;
    logic [3:0]  out_dst_reg;
    logic [15:0] out_Write_data;
    logic [15:0] out_Read_data;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_MemWrite   (MEM_MemWrite),
        .MEM_addr       (MEM_addr),
        .MEM_store_data (MEM_store_data),
        .MEM_Reg_Write  (MEM_Reg_Write),
        .MEM_dst_reg    (MEM_dst_reg),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_valid     (dmem_valid),
        .mem_stall      (mem_stall),
        .out_Reg_Write  (out_Reg_Write),
        .out_dst_reg    (out_dst_reg),
        .out_Write_data (out_Write_data),
        .out_Read_data  (out_Read_data),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        MEM_MemRead    = 1'b0;
        MEM_MemWrite   = 1'b0;
        MEM_Reg_Write  = 1'b0;
        MEM_dst_reg    = 4'h0;
        MEM_addr       = 16'h0000;
        MEM_store_data = 16'h0000;
    endtask

    // Runs one memory op whose inputs the caller has just set (at posedge+1).
    // dmem_valid is raised k cycles after the issue cycle (k = 0: never).
    // Returns on the posedge+1 following the first unstalled cycle.
    task automatic run_op(input int k, input logic [15:0] rdata,
                          output int stalls, output int reqs,
                          output logic we0, output logic [15:0] addr0, output logic [15:0] wdata0,
                          output logic rw_in_stall, output logic [15:0] rd,
                          output logic rw, output logic err, output logic done);
        int cyc;
        stalls = 0; reqs = 0; rw_in_stall = 1'b0; done = 1'b0;
        we0 = 1'bx; addr0 = 'x; wdata0 = 'x; rd = 'x; rw = 1'bx; err = 1'bx;
        cyc = 0;
        while (!done && cyc < 40) begin
            dmem_valid = (k > 0 && cyc == k);
            dmem_rdata = (k > 0 && cyc == k) ? rdata : 16'hFFFF;
            @(negedge clk);
            if (dmem_req) reqs++;
            if (cyc == 0) begin
                we0 = dmem_we; addr0 = dmem_addr; wdata0 = dmem_wdata;
            end
            if (mem_stall) begin
                stalls++;
                if (out_Reg_Write) rw_in_stall = 1'b1;
            end else begin
                done = 1'b1;
                rd   = out_Read_data;
                rw   = out_Reg_Write;
                err  = mem_err;
            end
            @(posedge clk); #1;
            cyc++;
        end
        dmem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        MEM_MemRead   = 1'b1;
        MEM_Reg_Write = 1'b1;
        MEM_addr      = 16'h0100;
        dmem_valid    = 1'b0;
        dmem_rdata    = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++; if (dmem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        n_checks++; if (out_Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", out_Reg_Write); end
        n_checks++; if (mem_err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
        n_checks++; if (out_Read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", out_Read_data); end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_nonmem();
        logic stalled;
        stalled = 1'b0;
        MEM_Reg_Write = 1'b1;
        MEM_dst_reg   = 4'h3;
        MEM_addr      = 16'h00A5;
        repeat (3) begin
            @(negedge clk);
            if (mem_stall || dmem_req) stalled = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall: got %b want 0", stalled); end
        @(negedge clk);
        n_checks++; if (out_Write_data !== 16'h00A5) begin n_fail++; $display("FAIL nonmem_wdata: got %h want 00a5", out_Write_data); end
        n_checks++; if (out_Reg_Write !== 1'b1) begin n_fail++; $display("FAIL nonmem_regwrite: got %b want 1", out_Reg_Write); end
        n_checks++; if (out_dst_reg !== 4'h3) begin n_fail++; $display("FAIL nonmem_dst: got %h want 3", out_dst_reg); end
        n_checks++; if (out_Read_data !== 16'h0000) begin n_fail++; $display("FAIL nonmem_rdata: got %h want 0000", out_Read_data); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_load();
        int st, rq; logic we0, rws, rw, err, dn; logic [15:0] a0, wd0, rd;
        MEM_MemRead = 1'b1; MEM_Reg_Write = 1'b1; MEM_dst_reg = 4'h5; MEM_addr = 16'h0010;
        run_op(3, 16'hBEEF, st, rq, we0, a0, wd0, rws, rd, rw, err, dn);
        idle_inputs();
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b want 1", dn); end
        n_checks++; if (rq != 1) begin n_fail++; $display("FAIL load_reqs: got %0d want 1", rq); end
        n_checks++; if (st != 4) begin n_fail++; $display("FAIL load_stalls: got %0d want 4", st); end
        n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL load_we: got %b want 0", we0); end
        n_checks++; if (a0 !== 16'h0010) begin n_fail++; $display("FAIL load_addr: got %h want 0010", a0); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL load_rdata: got %h want beef", rd); end
        n_checks++; if (rw !== 1'b1) begin n_fail++; $display("FAIL load_regwrite: got %b want 1", rw); end
        n_checks++; if (rws !== 1'b0) begin n_fail++; $display("FAIL load_bubble: got %b want 0", rws); end
    endtask

    task automatic test_store();
        int st, rq; logic we0, rws, rw, err, dn; logic [15:0] a0, wd0, rd;
        MEM_MemWrite = 1'b1; MEM_Reg_Write = 1'b0; MEM_addr = 16'h0020; MEM_store_data = 16'h1234;
        run_op(1, 16'h0000, st, rq, we0, a0, wd0, rws, rd, rw, err, dn);
        idle_inputs();
        n_checks++; if (we0 !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", we0); end
        n_checks++; if (wd0 !== 16'h1234) begin n_fail++; $display("FAIL store_wdata: got %h want 1234", wd0); end
        n_checks++; if (a0 !== 16'h0020) begin n_fail++; $display("FAIL store_addr: got %h want 0020", a0); end
        n_checks++; if (st != 2) begin n_fail++; $display("FAIL store_stalls: got %0d want 2", st); end
        n_checks++; if (rq != 1) begin n_fail++; $display("FAIL store_reqs: got %0d want 1", rq); end
        n_checks++; if ((rw | rws) !== 1'b0) begin n_fail++; $display("FAIL store_regwrite: got %b want 0", rw | rws); end
    endtask

    task automatic test_back_to_back();
        int st1, rq1, st2, rq2; logic we0, rws, rw1, rw2, err, dn; logic [15:0] a1, a2, wd0, rd1, rd2;
        MEM_MemRead = 1'b1; MEM_Reg_Write = 1'b1; MEM_dst_reg = 4'h1; MEM_addr = 16'h0002;
        run_op(1, 16'h1111, st1, rq1, we0, a1, wd0, rws, rd1, rw1, err, dn);
        MEM_dst_reg = 4'h2; MEM_addr = 16'h0004;
        run_op(2, 16'h2222, st2, rq2, we0, a2, wd0, rws, rd2, rw2, err, dn);
        idle_inputs();
        n_checks++; if (rq1 + rq2 != 2) begin n_fail++; $display("FAIL b2b_reqs: got %0d want 2", rq1 + rq2); end
        n_checks++; if (a2 !== 16'h0004) begin n_fail++; $display("FAIL b2b_addr2: got %h want 0004", a2); end
        n_checks++; if (rd1 !== 16'h1111) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 1111", rd1); end
        n_checks++; if (rd2 !== 16'h2222) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 2222", rd2); end
        n_checks++; if (st1 != 2 || st2 != 3) begin n_fail++; $display("FAIL b2b_stalls: got %0d,%0d want 2,3", st1, st2); end
        n_checks++; if ((rw1 & rw2) !== 1'b1) begin n_fail++; $display("FAIL b2b_regwrite: got %b%b want 11", rw1, rw2); end
    endtask

    task automatic test_timeout();
        int st, rq; logic we0, rws, rw, err, dn; logic [15:0] a0, wd0, rd;
        MEM_MemRead = 1'b1; MEM_Reg_Write = 1'b1; MEM_dst_reg = 4'h7; MEM_addr = 16'h0030;
        run_op(0, 16'h0000, st, rq, we0, a0, wd0, rws, rd, rw, err, dn);
        idle_inputs();
        n_checks++; if (st != 16) begin n_fail++; $display("FAIL timeout_stalls: got %0d want 16", st); end
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0000", rd); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", mem_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic bad;
        bad = 1'b0;
        MEM_MemRead = 1'b1; MEM_Reg_Write = 1'b1; MEM_addr = 16'h0040;
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL abort_issue: got %b want 1", dmem_req); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b want 0", mem_stall); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", mem_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        dmem_valid = 1'b1;
        dmem_rdata = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            if (dmem_req || mem_stall || out_Read_data !== 16'h0000) bad = 1'b1;
            @(posedge clk); #1;
            dmem_valid = 1'b0;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL abort_late_valid: got %b want 0", bad); end
        // A normal load right after the abort must see only its own data.
        begin
            int st, rq; logic we0, rws, rw, err, dn; logic [15:0] a0, wd0, rd;
            MEM_MemRead = 1'b1; MEM_Reg_Write = 1'b1; MEM_addr = 16'h0042;
            run_op(2, 16'h5A5A, st, rq, we0, a0, wd0, rws, rd, rw, err, dn);
            idle_inputs();
            n_checks++; if (rd !== 16'h5A5A || st != 3) begin n_fail++; $display("FAIL abort_next_load: got %h/%0d want 5a5a/3", rd, st); end
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
